sel_sequencer: RTL and testbench
================================

// Module: sel_sequencer
// PURPOSE
//   Upstream driver for the 3-to-8 one-hot output decoder. Produces the registered
//   3-bit select {sel1,sel2,sel3} and steps it through positions 0..7 at a
//   programmable dwell rate. Supports up, down, ping-pong and hold modes, plus a
//   synchronous load. Typical use: LED/row scan, channel rotation.
// PARAMETERS
//   PRESC_W   16   width of dwell prescaler counter and of dwell input
// PORTS
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   en         in   1        1 = sequencing active; 0 = freeze select, clear prescaler
//   mode       in   2        00 up, 01 down, 10 ping-pong, 11 hold
//   dwell      in   PRESC_W  clocks per position minus 1
//   load       in   1        1-cycle strobe: load load_val into select
//   load_val   in   3        position to load, bit2 = sel1
//   sel1       out  1        select MSB (registered)
//   sel2       out  1        select mid bit (registered)
//   sel3       out  1        select LSB (registered)
//   step_pulse out  1        1-cycle pulse, coincident with each select change made by stepping
//   wrap       out  1        1-cycle pulse on wrap (up 7->0, down 0->7) or ping-pong reversal
// BEHAVIOUR
//   Reset: pos=0 (sel1..3=000), prescaler cnt=0, dir=up, state=IDLE, step_pulse=0, wrap=0.
//   FSM (registered state):
//     IDLE: en=0. Prescaler held at 0; pos held. en=1 -> RUN, or HOLD if mode=11.
//     RUN:  prescaler counts each clock. tick when cnt>=dwell; on tick cnt<=0, pos steps.
//           en=0 -> IDLE. mode=11 -> HOLD.
//     HOLD: prescaler counts but tick is ignored; pos frozen; no pulses.
//           mode!=11 -> RUN. en=0 -> IDLE.
//   Timing: with en high from cycle 0, the first step is visible at cycle dwell+1.
//   Steady state: one step every dwell+1 clocks. dwell=0 steps every clock.
//   The >= compare handles a dwell decrease mid-count: the next cycle ticks at once.
//   Step rules:
//     up:        pos+1 mod 8; wrap=1 on 7->0.
//     down:      pos-1 mod 8; wrap=1 on 0->7.
//     ping-pong: move in dir; at 7 going up, dir<=down and pos<=6; at 0 going down,
//                dir<=up and pos<=1; wrap=1 on each reversal step.
//   Mode change: takes effect at the next tick. dir is kept when entering ping-pong.
//   load: highest priority, effective in any state including IDLE. Next cycle pos=load_val,
//     cnt=0, no step_pulse/wrap, dir unchanged. Simultaneous tick is discarded.
//   step_pulse/wrap are registered and assert in the same cycle the new pos appears.
//   Reset asserted mid-operation: all outputs go to reset values immediately (async).
// CONFIGURATION
//   SEL_SEQ_SKIP_MASK_EN defined: adds input skip_mask[7:0]. A step advances to the
//     nearest position in the current direction whose mask bit is 0. Search is at most
//     7 positions, combinational. wrap asserts if the path crosses 7/0 (up/down) or
//     reverses (ping-pong).
//     All 8 bits set: pos holds, no step_pulse. load ignores the mask.
//   Not defined: no skip_mask port; every position is visited.
// STRUCTURE
//   Package sel_seq_pkg: mode_t enum (MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_HOLD),
//     state_t enum (S_IDLE, S_RUN, S_HOLD), SEL_W=3, N_POS=8.
//   Sub-module sel_seq_prescaler: holds cnt, takes en/clr/dwell, outputs tick.
//   FSM and position/direction logic stay in the top module.
// TESTING
//   1 Reset release, en=0 for 10 clk -> sel=000, step_pulse=0, wrap=0 throughout.
//   2 mode=00, dwell=3, en=1 -> pos 1,2,..,7,0 every 4 clk. First change at clk 4.
//     wrap=1 only on the 7->0 step.
//   3 mode=10, dwell=0 -> 0,1..7,6..0,1. wrap on 7->6 and 0->1. step_pulse every clk.
//   4 load=1, load_val=5, in the same cycle as a tick (mode=01) -> pos=5, no step_pulse.
//     Next step 4 after dwell+1 clk.
//   5 mode=11 mid-run, pos=3 -> pos stays 3 for 20 clk. Return to 00 -> pos=4 at next tick.
//   6 SEL_SEQ_SKIP_MASK_EN, skip_mask=8'b0110_0110, mode=00 -> pos 0,3,4,7,0.
//     wrap on 7->0. skip_mask=8'hFF -> pos frozen.

Source files
------------

// File: rtl/sel_seq_pkg.sv
// Shared types and helpers for the select sequencer.
// Holds the mode/state encodings and the single-position step rule
// that both the plain and the skip-mask builds are built from.
package sel_seq_pkg;

    localparam int SEL_W = 3;
    localparam int N_POS = 8;

    localparam logic [SEL_W-1:0] POS_MIN = '0;
    localparam logic [SEL_W-1:0] POS_MAX = SEL_W'(N_POS - 1);

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] pos;
        logic             dir;
        logic             wrap;
    } step_t;

    // One position move in the given mode; wrap flags a 7/0 crossing or a
    // ping-pong reversal. Ping-pong bounces off the end instead of repeating it.
    function automatic step_t step_once(input logic [SEL_W-1:0] pos,
                                        input logic dir,
                                        input mode_t mode);
        step_t r;
        r.pos  = pos;
        r.dir  = dir;
        r.wrap = 1'b0;
        case (mode)
            MODE_UP: begin
                r.pos  = pos + 1'b1;
                r.wrap = (pos == POS_MAX);
            end
            MODE_DOWN: begin
                r.pos  = pos - 1'b1;
                r.wrap = (pos == POS_MIN);
            end
            MODE_PINGPONG: begin
                if (dir == DIR_UP) begin
                    if (pos == POS_MAX) begin
                        r.pos  = POS_MAX - 1'b1;
                        r.dir  = DIR_DOWN;
                        r.wrap = 1'b1;
                    end else begin
                        r.pos = pos + 1'b1;
                    end
                end else begin
                    if (pos == POS_MIN) begin
                        r.pos  = POS_MIN + 1'b1;
                        r.dir  = DIR_UP;
                        r.wrap = 1'b1;
                    end else begin
                        r.pos = pos - 1'b1;
                    end
                end
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sel_seq_prescaler.sv
// Dwell prescaler: counts clocks while enabled and flags a tick once the
// count reaches dwell. The >= compare means a dwell lowered below the
// current count ticks on the very next cycle instead of running to overflow.
module sel_seq_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] dwell,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = (cnt >= dwell);

    // Count while enabled, restart on every tick, and zero on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sel_sequencer.sv
// Select sequencer: steps a registered 3-bit select through positions 0..7
// at a programmable dwell rate in up, down, ping-pong or hold mode, with a
// synchronous load that overrides everything.
// Optional feature macro: SEL_SEQ_SKIP_MASK_EN adds skip_mask[7:0]; a step
// then lands on the nearest unmasked position in the direction of travel.
module sel_sequencer
    import sel_seq_pkg::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] dwell,
    input  logic               load,
    input  logic [SEL_W-1:0]   load_val,
`ifdef SEL_SEQ_SKIP_MASK_EN
    input  logic [N_POS-1:0]   skip_mask,
`endif
    output logic               sel1,
    output logic               sel2,
    output logic               sel3,
    output logic               step_pulse,
    output logic               wrap
);

    state_t           state;
    state_t           state_next;
    mode_t            mode_e;
    logic [SEL_W-1:0] pos;
    logic             dir;
    logic             tick;
    logic             do_step;
    logic             can_step;
    step_t            next_step;

    assign mode_e = mode_t'(mode);
    assign {sel1, sel2, sel3} = pos;

    // The prescaler only runs while en is high; a load restarts the dwell.
    sel_seq_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (!en || load),
        .dwell (dwell),
        .tick  (tick)
    );

    // Next-state logic: en gates activity, mode 11 parks in HOLD.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (en) state_next = (mode_e == MODE_HOLD) ? S_HOLD : S_RUN;
            end
            S_RUN: begin
                if (!en)                     state_next = S_IDLE;
                else if (mode_e == MODE_HOLD) state_next = S_HOLD;
            end
            S_HOLD: begin
                if (!en)                     state_next = S_IDLE;
                else if (mode_e != MODE_HOLD) state_next = S_RUN;
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef SEL_SEQ_SKIP_MASK_EN
    logic [SEL_W-1:0] cand;
    logic             cand_dir;
    logic             crossed;
    logic             found;
    step_t            s1;

    // Walk up to seven single steps and stop at the first unmasked position;
    // wrap accumulates over the whole path so a skipped-over 7/0 still counts.
    always_comb begin
        cand           = pos;
        cand_dir       = dir;
        crossed        = 1'b0;
        found          = 1'b0;
        s1             = '0;
        next_step.pos  = pos;
        next_step.dir  = dir;
        next_step.wrap = 1'b0;
        for (int i = 0; i < N_POS - 1; i++) begin
            if (!found) begin
                s1       = step_once(cand, cand_dir, mode_e);
                cand     = s1.pos;
                cand_dir = s1.dir;
                crossed  = crossed | s1.wrap;
                if (!skip_mask[cand]) begin
                    found          = 1'b1;
                    next_step.pos  = cand;
                    next_step.dir  = cand_dir;
                    next_step.wrap = crossed;
                end
            end
        end
        can_step = found;
    end
`else
    // Every position is visited, so the next position is a single step.
    always_comb begin
        next_step = step_once(pos, dir, mode_e);
        can_step  = 1'b1;
    end
`endif

    // A step happens on a tick only when we are (or are about to be) running;
    // this lets the very first tick out of IDLE step without a lost cycle.
    always_comb begin
        do_step = (state_next == S_RUN) && tick && !load && can_step;
    end

    // State, position, direction and the registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pos        <= '0;
            dir        <= DIR_UP;
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state      <= state_next;
            step_pulse <= do_step;
            wrap       <= do_step && next_step.wrap;
            if (load) begin
                pos <= load_val;
            end else if (do_step) begin
                pos <= next_step.pos;
                dir <= next_step.dir;
            end
        end
    end

endmodule

// File: tb/tb_sel_sequencer.sv
// Directed testbench for sel_sequencer. Each scenario task drives its own
// stimulus and compares against hand-computed positions and pulse flags.
// Build with SEL_SEQ_SKIP_MASK_EN to add the skip-mask scenario.
module tb_sel_sequencer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] dwell;
    logic        load;
    logic [2:0]  load_val;
`ifdef SEL_SEQ_SKIP_MASK_EN
    logic [7:0]  skip_mask;
`endif
    logic        sel1, sel2, sel3;
    logic        step_pulse;
    logic        wrap;

    int n_checks;
    int n_fail;

    wire [2:0] sel = {sel1, sel2, sel3};

    sel_sequencer #(.PRESC_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .dwell      (dwell),
        .load       (load),
        .load_val   (load_val),
`ifdef SEL_SEQ_SKIP_MASK_EN
        .skip_mask  (skip_mask),
`endif
        .sel1       (sel1),
        .sel2       (sel2),
        .sel3       (sel3),
        .step_pulse (step_pulse),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; dwell = 16'd0;
        load = 1'b0; load_val = 3'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sel, step_pulse, wrap} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_hold: sel/step/wrap=%b required=00000", {sel, step_pulse, wrap});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({sel, step_pulse, wrap} !== 5'b0) begin
                n_fail++;
                $display("[TB] FAIL idle_after_reset c%0d: sel/step/wrap=%b required=00000", c, {sel, step_pulse, wrap});
            end
        end
    endtask

    task automatic test_up();
        logic [2:0] exp_pos;
        exp_pos = 3'd0;
        mode = 2'b00; dwell = 16'd3; en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                if (c < 4) begin
                    n_checks++;
                    if (sel !== exp_pos || step_pulse !== 1'b0 || wrap !== 1'b0) begin
                        n_fail++;
                        $display("[TB] FAIL up_dwell k%0d c%0d: sel=%0d step=%b wrap=%b required sel=%0d step=0 wrap=0",
                                 k, c, sel, step_pulse, wrap, exp_pos);
                    end
                end else begin
                    exp_pos = exp_pos + 3'd1;
                    n_checks++;
                    if (sel !== exp_pos || step_pulse !== 1'b1 || wrap !== (k == 8)) begin
                        n_fail++;
                        $display("[TB] FAIL up_step k%0d: sel=%0d step=%b wrap=%b required sel=%0d step=1 wrap=%b",
                                 k, sel, step_pulse, wrap, exp_pos, (k == 8));
                    end
                end
            end
        end
    endtask

    task automatic test_pingpong();
        logic [2:0] exp_seq [15];
        logic       exp_wrap [15];
        exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                    3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
        exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        mode = 2'b10; dwell = 16'd0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_checks++;
            if (sel !== exp_seq[i] || step_pulse !== 1'b1 || wrap !== exp_wrap[i]) begin
                n_fail++;
                $display("[TB] FAIL pingpong i%0d: sel=%0d step=%b wrap=%b required sel=%0d step=1 wrap=%b",
                         i, sel, step_pulse, wrap, exp_seq[i], exp_wrap[i]);
            end
        end
    endtask

    task automatic test_load();
        logic [2:0] exp_seq [6];
        exp_seq = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        // Position is 1 with cnt=0; dwell=2 ticks on the third edge.
        mode = 2'b01; dwell = 16'd2;
        repeat (2) @(negedge clk);
        n_checks++;
        if (sel !== 3'd1 || step_pulse !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL load_pre: sel=%0d step=%b required sel=1 step=0", sel, step_pulse);
        end
        load = 1'b1; load_val = 3'd5;
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        if (sel !== 3'd5 || step_pulse !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL load_vs_tick: sel=%0d step=%b wrap=%b required sel=5 step=0 wrap=0", sel, step_pulse, wrap);
        end
        for (int k = 0; k < 6; k++) begin
            repeat (2) @(negedge clk);
            n_checks++;
            if (step_pulse !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL down_dwell k%0d: step=%b required step=0", k, step_pulse);
            end
            @(negedge clk);
            n_checks++;
            if (sel !== exp_seq[k] || step_pulse !== 1'b1 || wrap !== (k == 5)) begin
                n_fail++;
                $display("[TB] FAIL down_step k%0d: sel=%0d step=%b wrap=%b required sel=%0d step=1 wrap=%b",
                         k, sel, step_pulse, wrap, exp_seq[k], (k == 5));
            end
        end
    endtask

    task automatic test_hold();
        logic seen;
        // Load works while idle.
        en = 1'b0;
        @(negedge clk);
        load = 1'b1; load_val = 3'd3;
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        if (sel !== 3'd3 || step_pulse !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL load_idle: sel=%0d step=%b required sel=3 step=0", sel, step_pulse);
        end
        mode = 2'b11; dwell = 16'd1; en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (sel !== 3'd3 || step_pulse !== 1'b0 || wrap !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL hold c%0d: sel=%0d step=%b wrap=%b required sel=3 step=0 wrap=0", c, sel, step_pulse, wrap);
            end
        end
        mode = 2'b00;
        seen = 1'b0;
        for (int c = 0; c < 2 && !seen; c++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("[TB] FAIL hold_release_timeout: step seen=0 required step within 2 clk");
        end else if (sel !== 3'd4 || wrap !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL hold_release: sel=%0d wrap=%b required sel=4 wrap=0", sel, wrap);
        end
    endtask

    task automatic test_async_reset();
        dwell = 16'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (step_pulse !== 1'b1 || sel !== 3'd7) begin
            n_fail++;
            $display("[TB] FAIL pre_async: sel=%0d step=%b required sel=7 step=1", sel, step_pulse);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sel, step_pulse, wrap} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: sel/step/wrap=%b required=00000", {sel, step_pulse, wrap});
        end
        @(negedge clk);
        rst_n = 1'b1;
        // dwell=0 with en already high: first step on the first edge.
        @(negedge clk);
        n_checks++;
        if (sel !== 3'd1 || step_pulse !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL first_step_dwell0: sel=%0d step=%b required sel=1 step=1", sel, step_pulse);
        end
    endtask

`ifdef SEL_SEQ_SKIP_MASK_EN
    task automatic test_skip_mask();
        logic [2:0] exp_seq [4];
        exp_seq = '{3'd3, 3'd4, 3'd7, 3'd0};
        rst_n = 1'b0; en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        skip_mask = 8'b0110_0110; mode = 2'b00; dwell = 16'd0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (sel !== exp_seq[k] || step_pulse !== 1'b1 || wrap !== (k == 3)) begin
                n_fail++;
                $display("[TB] FAIL skip k%0d: sel=%0d step=%b wrap=%b required sel=%0d step=1 wrap=%b",
                         k, sel, step_pulse, wrap, exp_seq[k], (k == 3));
            end
        end
        skip_mask = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (sel !== 3'd0 || step_pulse !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL skip_all c%0d: sel=%0d step=%b required sel=0 step=0", c, sel, step_pulse);
            end
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef SEL_SEQ_SKIP_MASK_EN
        skip_mask = 8'h00;
`endif
        test_reset();
        test_up();
        test_pingpong();
        test_load();
        test_hold();
        test_async_reset();
`ifdef SEL_SEQ_SKIP_MASK_EN
        test_skip_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
